// File: rtl/draw_pkg.sv
// draw_pkg: constants and types shared by the draw scheduler files.
//   SCREEN_W / SCREEN_H : visible VGA area used for optional clipping
//   BLACK..WHITE        : 3-bit RGB colour constants
//   state_t             : scheduler FSM states
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
//   req       in  N      request vector
//   ptr       in  IDX_W  index of the last granted requester
//   grant     out N      one-hot grant (zero when no request)
//   grant_idx out IDX_W  index of the granted requester
//   any       out 1      at least one request present
// The search starts at ptr+1 and wraps, so ptr itself has lowest priority.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates NUM_REQ rectangle requesters and rasterises the
// granted rectangle one pixel per cycle towards a VGA adapter.
//   clock        in   system clock (rising edge)
//   reset        in   synchronous active-high reset
//   req          in   per-requester level request
//   rect_x/y     in   packed 8-bit top-left corner per requester
//   rect_w_m1    in   packed width-1 per requester  (DIM_W bits each)
//   rect_h_m1    in   packed height-1 per requester (DIM_W bits each)
//   rect_colour  in   packed 3-bit colour per requester
//   ack          out  one-cycle pulse to the requester whose rectangle finished
//   busy         out  FSM not in IDLE
//   x, y, colour out  registered pixel to the VGA adapter
//   plot         out  registered pixel write strobe
// Build option: define DRAW_SCHEDULER_CLIP_EN to suppress plot for pixels
// outside SCREEN_W x SCREEN_H (the cycle is still spent, x/y still driven).
//
// Pixel pipeline: the counters issue a pixel during a DRAW cycle and the
// output registers present it in the following cycle. DRAW therefore lasts
// one cycle longer than the pixel count: the FSM leaves DRAW only once the
// last pixel is actually on the outputs, so DONE never shows a plot.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIM_W   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*8-1:0]     rect_x,
  input  logic [NUM_REQ*8-1:0]     rect_y,
  input  logic [NUM_REQ*DIM_W-1:0] rect_w_m1,
  input  logic [NUM_REQ*DIM_W-1:0] rect_h_m1,
  input  logic [NUM_REQ*3-1:0]     rect_colour,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic [7:0]               x,
  output logic [7:0]               y,
  output logic [2:0]               colour,
  output logic                     plot
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     rr_ptr, gnt_idx;
  logic [NUM_REQ-1:0]   gnt_oh, cur_oh;
  logic                 gnt_any;

  logic [7:0]           sel_x, sel_y, lx, ly;
  logic [DIM_W-1:0]     sel_w, sel_h, lw, lh, col, row;
  logic [2:0]           sel_c, lcol;

  logic                 cnt_done;   // all pixels issued, waiting for output stage
  logic                 last_q;     // last pixel is on the outputs this cycle
  logic                 issue, issue_last, pix_on;
  logic [7:0]           xs, ys;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (gnt_oh),
    .grant_idx (gnt_idx),
    .any       (gnt_any)
  );

  // Field mux for the winning requester, constant-indexed per lane.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_w = '0;
    sel_h = '0;
    sel_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_x = rect_x[i*8 +: 8];
        sel_y = rect_y[i*8 +: 8];
        sel_w = rect_w_m1[i*DIM_W +: DIM_W];
        sel_h = rect_h_m1[i*DIM_W +: DIM_W];
        sel_c = rect_colour[i*3 +: 3];
      end
    end
  end

  // Pixel issue stage; sums wrap mod 256 by width.
  always_comb begin
    issue      = (state == DRAW) && !cnt_done;
    issue_last = issue && (col == lw) && (row == lh);
    xs         = lx + 8'(col);
    ys         = ly + 8'(row);
  end

`ifdef DRAW_SCHEDULER_CLIP_EN
  assign pix_on = (int'(xs) < SCREEN_W) && (int'(ys) < SCREEN_H);
`else
  assign pix_on = 1'b1;
`endif

  assign busy = (state != IDLE);

  // FSM
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = DRAW;
      DRAW:    if (last_q)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latched rectangle, raster counters, output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      cur_oh   <= '0;
      lx       <= '0;
      ly       <= '0;
      lw       <= '0;
      lh       <= '0;
      lcol     <= BLACK;
      col      <= '0;
      row      <= '0;
      cnt_done <= 1'b0;
      last_q   <= 1'b0;
      ack      <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= BLACK;
      plot     <= 1'b0;
    end else begin
      ack    <= '0;
      x      <= issue ? xs : 8'd0;
      y      <= issue ? ys : 8'd0;
      colour <= issue ? lcol : BLACK;
      plot   <= issue && pix_on;
      last_q <= issue_last;

      case (state)
        IDLE: begin
          if (gnt_any) begin
            rr_ptr   <= gnt_idx;
            cur_oh   <= gnt_oh;
            lx       <= sel_x;
            ly       <= sel_y;
            lw       <= sel_w;
            lh       <= sel_h;
            lcol     <= sel_c;
            col      <= '0;
            row      <= '0;
            cnt_done <= 1'b0;
          end
        end
        DRAW: begin
          if (issue) begin
            if (col == lw) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (issue_last) cnt_done <= 1'b1;
          end
          // Registered so the pulse coincides with the DONE state.
          if (last_q) ack <= cur_oh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DIM_W   = 4;

  typedef struct packed {
    logic [7:0] px;
    logic [7:0] py;
    logic [2:0] pc;
  } pix_t;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*8-1:0]     rect_x, rect_y;
  logic [NUM_REQ*DIM_W-1:0] rect_w_m1, rect_h_m1;
  logic [NUM_REQ*3-1:0]     rect_colour;
  logic [NUM_REQ-1:0]       ack;
  logic                     busy;
  logic [7:0]               x, y;
  logic [2:0]               colour;
  logic                     plot;

  draw_scheduler #(.NUM_REQ(NUM_REQ), .DIM_W(DIM_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w_m1   (rect_w_m1),
    .rect_h_m1   (rect_h_m1),
    .rect_colour (rect_colour),
    .ack         (ack),
    .busy        (busy),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot)
  );

  initial forever #5 clock = ~clock;

  // Passive monitor: logs what the VGA side and requesters observe.
  int                 cyc = 0, rise_cyc = 0, busy_total = 0;
  int                 pix_n = 0, ack_n = 0, ack_cyc = 0, multi_ack = 0;
  logic               prev_busy = 1'b0;
  logic [NUM_REQ-1:0] ack_val = '0;
  pix_t               obs_pix [0:4095];
  int                 obs_cyc [0:4095];

  always @(negedge clock) begin
    cyc       <= cyc + 1;
    prev_busy <= busy;
    if (busy && !prev_busy) rise_cyc <= cyc;
    if (busy) busy_total <= busy_total + 1;
    if (plot) begin
      obs_pix[pix_n % 4096] <= '{x, y, colour};
      obs_cyc[pix_n % 4096] <= cyc;
      pix_n <= pix_n + 1;
    end
    if (ack != '0) begin
      ack_n   <= ack_n + 1;
      ack_val <= ack;
      ack_cyc <= cyc;
    end
    if ($countones(ack) > 1) multi_ack <= multi_ack + 1;
  end

  // Reference model: expected raster of one rectangle.
  pix_t exp_pix [0:1023];
  int   exp_off [0:1023];
  int   exp_n;

  task automatic build_model(input int rx, ry, rw, rh, rc);
    int xx, yy;
    bit vis;
    exp_n = 0;
    for (int r = 0; r <= rh; r++) begin
      for (int c = 0; c <= rw; c++) begin
        xx  = (rx + c) % 256;
        yy  = (ry + r) % 256;
        vis = 1'b1;
`ifdef DRAW_SCHEDULER_CLIP_EN
        vis = (xx < 160) && (yy < 120);
`endif
        if (vis) begin
          exp_pix[exp_n] = '{8'(xx), 8'(yy), 3'(rc)};
          exp_off[exp_n] = r * (rw + 1) + c;
          exp_n++;
        end
      end
    end
  endtask

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
  endtask

  task automatic wait_cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic load(input int idx, rx, ry, rw, rh, rc);
    rect_x[idx*8 +: 8]             = 8'(rx);
    rect_y[idx*8 +: 8]             = 8'(ry);
    rect_w_m1[idx*DIM_W +: DIM_W]  = DIM_W'(rw);
    rect_h_m1[idx*DIM_W +: DIM_W]  = DIM_W'(rh);
    rect_colour[idx*3 +: 3]        = 3'(rc);
  endtask

  int p0, a0, b0;

  task automatic snap();
    p0 = pix_n;
    a0 = ack_n;
    b0 = busy_total;
  endtask

  // Wait for the ack, release req, then compare everything seen against the model.
  task automatic finish(input int idx, rx, ry, rw, rh, rc, input bit perturb);
    int n, k;
    n = (rw + 1) * (rh + 1);
    if (perturb) begin
      repeat (5) wait_cyc();
      load(idx, $urandom_range(0, 255), ry, rw, rh, $urandom_range(0, 7));
    end
    k = 0;
    while (ack_n == a0 && k < 2000) begin
      wait_cyc();
      k++;
    end
    chk("ack_count", 32'(ack_n - a0), 32'd1);
    chk("ack_onehot", 32'(ack_val), 32'(1 << idx));
    @(posedge clock);
    #1 req[idx] = 1'b0;
    repeat (3) wait_cyc();
    chk("idle_plot", 32'(plot), 32'd0);
    chk("idle_x", 32'(x), 32'd0);
    build_model(rx, ry, rw, rh, rc);
    chk("pix_count", 32'(pix_n - p0), 32'(exp_n));
    for (int i = 0; i < exp_n && i < pix_n - p0; i++) begin
      chk("pix", 32'(obs_pix[(p0 + i) % 4096]), 32'(exp_pix[i]));
      chk("pix_cyc", 32'(obs_cyc[(p0 + i) % 4096]), 32'(rise_cyc + 1 + exp_off[i]));
    end
    chk("busy_cycles", 32'(busy_total - b0), 32'(n + 2));
    chk("ack_cyc", 32'(ack_cyc), 32'(rise_cyc + n + 1));
  endtask

  task automatic run_rect(input int idx, rx, ry, rw, rh, rc, input bit perturb);
    load(idx, rx, ry, rw, rh, rc);
    snap();
    req[idx] = 1'b1;
    finish(idx, rx, ry, rw, rh, rc, perturb);
  endtask

  initial begin
    int k, order [4], a_start;
    reset = 1'b1;
    req = '0;
    rect_x = '0; rect_y = '0; rect_w_m1 = '0; rect_h_m1 = '0; rect_colour = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    wait_cyc();

    // Reset state
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_xy", 32'({x, y}), 32'd0);
    chk("rst_colour", 32'(colour), 32'd0);

    // 16x2 white rectangle on requester 0
    run_rect(0, 5, 110, 15, 1, 7, 1'b0);
    // x wraps past 255
    run_rect(3, 250, 40, 7, 0, 2, 1'b0);
    // straddles the clip window corner
    run_rect(2, 156, 119, 7, 1, 4, 1'b0);
    // fields changed mid-draw must not matter
    run_rect(1, 30, 60, 15, 1, 5, 1'b1);

    // Randomised rectangles
    for (int t = 0; t < 8; t++) begin
      run_rect($urandom_range(0, NUM_REQ - 1), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 7), 1'b0);
    end

    // Round-robin: 0 and 2 up front, 1 joins during the first draw, all keep requesting
    load(0, 10, 10, 1, 1, 1);
    load(1, 20, 20, 1, 1, 2);
    load(2, 30, 30, 1, 1, 3);
    a_start = ack_n;
    req[0] = 1'b1;
    req[2] = 1'b1;
    repeat (3) wait_cyc();
    req[1] = 1'b1;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      while (ack_n <= a_start + g && k < 200) begin
        wait_cyc();
        k++;
      end
      order[g] = -1;
      for (int b = 0; b < NUM_REQ; b++) if (ack_val[b]) order[g] = b;
    end
    @(posedge clock);
    #1 req = '0;
    repeat (4) wait_cyc();
    chk("rr_0", 32'(order[0]), 32'd0);
    chk("rr_1", 32'(order[1]), 32'd1);
    chk("rr_2", 32'(order[2]), 32'd2);
    chk("rr_3", 32'(order[3]), 32'd0);

    // Reset at the 6th pixel abandons the rectangle; held req restarts it in full
    load(1, 100, 50, 15, 1, 6);
    p0 = pix_n;
    a_start = ack_n;
    req[1] = 1'b1;
    k = 0;
    while (pix_n - p0 < 6 && k < 200) begin
      wait_cyc();
      k++;
    end
    chk("abort_reach6", 32'(pix_n - p0), 32'd6);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    wait_cyc();
    chk("abort_plot", 32'(plot), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_noack", 32'(ack_n - a_start), 32'd0);
    snap();
    finish(1, 100, 50, 15, 1, 6, 1'b0);

    chk("single_ack", 32'(multi_ack), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
